star_match_sequencer: RTL

Sequencer that takes one CAM match vector at a time and returns every set match line, one per handshake, from the highest index to the lowest. It holds a residual copy of the vector and feeds it to a combinational highest-bit selector. After each accepted hit it clears that bit, until the vector is exhausted, a hit limit is reached or the scan is aborted. It sits between the STAR CAM match output and the downstream lookup/update logic.

---
 rtl/star_match_sequencer_pkg.sv | 19 +
 rtl/star_match_sequencer_if.sv | 27 ++
 rtl/def.sv | 7 +
 rtl/star_msb_select.sv | 32 +++
 rtl/star_match_sequencer.sv | 73 +++++++
 5 files changed

// File: rtl/star_match_sequencer_pkg.sv
// Shared types for the match sequencer. Sizing macros are guarded so this file
// works whether or not def.sv was seen first.
`ifndef STAR_CAM_len
`define STAR_CAM_len 512
`endif
`ifndef STAR_IDX_len
`define STAR_IDX_len 9
`endif

package star_match_pkg;
    localparam int CAM_LEN_DEF = `STAR_CAM_len;
    localparam int IDX_W_DEF   = `STAR_IDX_len;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        MISS = 2'd2
    } state_t;
endpackage

// File: rtl/star_match_sequencer_if.sv
// Match-vector input and hit-response output bundle of the sequencer.
interface star_match_sequencer_if #(
    parameter int CAM_LEN = star_match_pkg::CAM_LEN_DEF,
    parameter int IDX_W   = $clog2(CAM_LEN)
);
    logic               mv_valid;
    logic               mv_ready;
    logic [CAM_LEN-1:0] mv_data;
    logic [IDX_W:0]     cfg_max_hits;
    logic               abort;
    logic               hit_valid;
    logic               hit_ready;
    logic [CAM_LEN-1:0] hit_onehot;
    logic [IDX_W-1:0]   hit_idx;
    logic               hit_miss;
    logic               hit_last;
    logic [IDX_W:0]     hit_cnt;

    modport master (
        output mv_valid, mv_data, cfg_max_hits, abort, hit_ready,
        input  mv_ready, hit_valid, hit_onehot, hit_idx, hit_miss, hit_last, hit_cnt
    );
    modport slave (
        input  mv_valid, mv_data, cfg_max_hits, abort, hit_ready,
        output mv_ready, hit_valid, hit_onehot, hit_idx, hit_miss, hit_last, hit_cnt
    );
endinterface

// File: rtl/def.sv
// Global sizing macros for the STAR CAM datapath.
`ifndef STAR_CAM_len
`define STAR_CAM_len 512
`endif
`ifndef STAR_IDX_len
`define STAR_IDX_len 9
`endif

// File: rtl/star_msb_select.sv
// Highest-set-bit selector: halves the search window each stage, one index bit
// per stage, MSB first. Also flags an input with exactly one bit set.
module star_msb_select #(
    parameter int CAM_LEN = star_match_pkg::CAM_LEN_DEF,
    parameter int IDX_W   = $clog2(CAM_LEN)
) (
    input  logic [CAM_LEN-1:0] i_vec,
    output logic [CAM_LEN-1:0] o_onehot,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_one
);
    logic w_any;

    for (genvar k = 0; k < IDX_W; k++) begin : g_st
        localparam int W = CAM_LEN >> k;
        localparam int H = W / 2;
        logic [W-1:0] w_in;
        logic [H-1:0] w_out;
        if (k == 0) begin : g_first
            assign w_in = i_vec;
        end else begin : g_next
            assign w_in = g_st[k-1].w_out;
        end
        // Prefer the upper half whenever it holds any set bit.
        assign o_idx[IDX_W-1-k] = |w_in[W-1:H];
        assign w_out = o_idx[IDX_W-1-k] ? w_in[W-1:H] : w_in[H-1:0];
    end

    assign w_any    = g_st[IDX_W-1].w_out[0];
    assign o_onehot = w_any ? (CAM_LEN'(1) << o_idx) : '0;
    assign o_one    = w_any && ((i_vec & (i_vec - CAM_LEN'(1))) == '0);
endmodule

// File: rtl/star_match_sequencer.sv
// Walks a CAM match vector from highest to lowest set line, one hit per
// handshake, with optional hit limit, abort and back-to-back vector loading.
module star_match_sequencer
    import star_match_pkg::*;
#(
    parameter int CAM_LEN = CAM_LEN_DEF,
    parameter int IDX_W   = $clog2(CAM_LEN)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    star_match_sequencer_if.slave bus
);
    state_t             r_state;
    logic [CAM_LEN-1:0] r_resid;
    logic [IDX_W:0]     r_limit;
    logic [IDX_W:0]     r_cnt;

    logic [CAM_LEN-1:0] w_onehot;
    logic [IDX_W-1:0]   w_idx;
    logic               w_one;
    logic [IDX_W:0]     w_cnt_nx;
    logic               w_last;
    logic               w_hs;
    logic               w_acc;

    star_msb_select #(.CAM_LEN(CAM_LEN), .IDX_W(IDX_W)) u_sel (
        .i_vec   (r_resid),
        .o_onehot(w_onehot),
        .o_idx   (w_idx),
        .o_one   (w_one)
    );

    assign w_cnt_nx = r_cnt + (IDX_W+1)'(1);
    assign w_last   = (r_state == MISS) ||
                      ((r_state == SCAN) && (w_one || ((r_limit != '0) && (w_cnt_nx == r_limit))));

    assign bus.hit_valid  = (r_state != IDLE);
    assign bus.hit_miss   = (r_state == MISS);
    assign bus.hit_last   = w_last;
    assign bus.hit_onehot = (r_state == SCAN) ? w_onehot : '0;
    assign bus.hit_idx    = (r_state == SCAN) ? w_idx : '0;
    assign bus.hit_cnt    = r_cnt;

    assign w_hs         = bus.hit_valid && bus.hit_ready;
    // Final handshake frees the slot for a new vector in the same cycle.
    assign bus.mv_ready = (r_state == IDLE) || (w_hs && w_last && !bus.abort);
    assign w_acc        = bus.mv_valid && bus.mv_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_resid <= '0;
            r_limit <= '0;
            r_cnt   <= '0;
        end else if ((r_state != IDLE) && bus.abort) begin
            r_state <= IDLE;
            r_resid <= '0;
            if (w_hs) r_cnt <= w_cnt_nx;
        end else begin
            if (w_hs) begin
                r_resid <= r_resid & ~w_onehot;
                r_cnt   <= w_cnt_nx;
                if (w_last) r_state <= IDLE;
            end
            if (w_acc) begin
                r_resid <= bus.mv_data;
                r_limit <= bus.cfg_max_hits;
                r_cnt   <= '0;
                r_state <= (|bus.mv_data) ? SCAN : MISS;
            end
        end
    end
endmodule
